// File: rtl/param_fir.sv
// ---------------------------------------------------------------------------
// param_fir
//
// Purpose:
//   Parametric direct-form FIR filter with a two-mode controller. In LOAD the
//   block accepts N_TAPS coefficients over a valid/ready handshake (h[N-1]
//   first, h[0] last). In RUN it accepts samples, computes
//   y[n] = sum_k h[k]*x[n-k] at full precision, rounds half toward +inf,
//   shifts right by SHIFT, saturates to BW_OUT bits and registers the result
//   behind a single-entry valid/ready output stage.
//
// States:
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_LOAD | coefficient shift-in; coef_ready=1 (once out of reset)
//   ST_RUN  | filtering; samples accepted when the output stage has room
//
// Ports:
//   clk         in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   load_start  in   pulse: abandon current mode, clear history, enter LOAD
//   coef_valid  in   coef_data valid this cycle
//   coef_data   in   signed coefficient word   [BW_COEF]
//   coef_ready  out  coefficient accepted this cycle if coef_valid
//   in_valid    in   in_data valid this cycle
//   in_data     in   signed sample              [BW_IN]
//   in_ready    out  sample accepted this cycle if in_valid
//   out_valid   out  out_data holds a result
//   out_data    out  signed filtered sample     [BW_OUT]
//   out_ready   in   downstream consumes out_data
//   running     out  high in RUN
// ---------------------------------------------------------------------------
module param_fir #(
    parameter int N_TAPS  = 4,
    parameter int BW_IN   = 6,
    parameter int BW_COEF = 6,
    parameter int BW_OUT  = 8,
    parameter int SHIFT   = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      load_start,
    input  logic                      coef_valid,
    input  logic signed [BW_COEF-1:0] coef_data,
    output logic                      coef_ready,
    input  logic                      in_valid,
    input  logic signed [BW_IN-1:0]   in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic signed [BW_OUT-1:0]  out_data,
    input  logic                      out_ready,
    output logic                      running
);

    localparam int PROD_W = BW_IN + BW_COEF;
    localparam int ACC_W  = PROD_W + $clog2(N_TAPS);
    localparam int CNT_W  = $clog2(N_TAPS + 1);

    // Rounding constant 2^(SHIFT-1), one bit wider than the accumulator so
    // the addition can never wrap.
    localparam logic signed [ACC_W:0]    RND_HALF = (ACC_W+1)'(1) <<< (SHIFT - 1);
    localparam logic signed [BW_OUT-1:0] OUT_MAX  = {1'b0, {(BW_OUT-1){1'b1}}};
    localparam logic signed [BW_OUT-1:0] OUT_MIN  = {1'b1, {(BW_OUT-1){1'b0}}};

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [CNT_W-1:0]           r_count;
    logic [CNT_W-1:0]           w_count_nxt;
    logic                       r_armed;
    logic signed [BW_COEF-1:0]  r_coef [N_TAPS];
    logic signed [BW_IN-1:0]    r_dly  [N_TAPS-1];
    logic                       r_out_valid;
    logic signed [BW_OUT-1:0]   r_out_data;

    logic                       w_coef_acc;
    logic                       w_smp_acc;
    logic signed [PROD_W-1:0]   w_prod [N_TAPS];
    logic signed [ACC_W-1:0]    w_acc;
    logic signed [ACC_W:0]      w_rnd;
    logic signed [ACC_W:0]      w_shr;
    logic [ACC_W-BW_OUT+1:0]    w_hi;
    logic signed [BW_OUT-1:0]   w_sat;

    // -----------------------------------------------------------------------
    // Handshakes. r_armed holds coef_ready low until the first edge after
    // reset release, so coef_ready is 0 throughout reset.
    // -----------------------------------------------------------------------
    always_comb begin
        coef_ready = r_armed & (r_state == ST_LOAD);
        running    = (r_state == ST_RUN);
        in_ready   = (r_state == ST_RUN) & (~r_out_valid | out_ready);
        out_valid  = r_out_valid;
        out_data   = r_out_data;
        // load_start discards anything presented alongside it
        w_coef_acc = coef_valid & coef_ready & ~load_start;
        w_smp_acc  = in_valid & in_ready & ~load_start;
    end

    // -----------------------------------------------------------------------
    // Controller
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_LOAD;
            r_count <= '0;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_armed <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        if (load_start) begin
            w_state_nxt = ST_LOAD;
            w_count_nxt = '0;
        end else if (w_coef_acc) begin
            w_count_nxt = r_count + CNT_W'(1);
            if (r_count == CNT_W'(N_TAPS - 1)) begin
                w_state_nxt = ST_RUN;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Coefficient shift register: new word enters at index 0 and moves up,
    // so the first word loaded (h[N-1]) ends at index N_TAPS-1.
    // Coefficients survive load_start and are only replaced by a new load.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N_TAPS; k++) begin
                r_coef[k] <= '0;
            end
        end else if (w_coef_acc) begin
            r_coef[0] <= coef_data;
            for (int k = 1; k < N_TAPS; k++) begin
                r_coef[k] <= r_coef[k-1];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Delay line: r_dly[k] holds x[n-1-k]; the current sample comes straight
    // from in_data, so only N_TAPS-1 past samples are stored.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N_TAPS - 1; k++) begin
                r_dly[k] <= '0;
            end
        end else if (load_start) begin
            for (int k = 0; k < N_TAPS - 1; k++) begin
                r_dly[k] <= '0;
            end
        end else if (w_smp_acc) begin
            r_dly[0] <= in_data;
            for (int k = 1; k < N_TAPS - 1; k++) begin
                r_dly[k] <= r_dly[k-1];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Multiply-accumulate, rounding and saturation
    // -----------------------------------------------------------------------
    always_comb begin
        w_prod[0] = PROD_W'(in_data) * PROD_W'(r_coef[0]);
        for (int k = 1; k < N_TAPS; k++) begin
            w_prod[k] = PROD_W'(r_dly[k-1]) * PROD_W'(r_coef[k]);
        end
        w_acc = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            w_acc = w_acc + ACC_W'(w_prod[k]);
        end
    end

    always_comb begin
        w_rnd = (ACC_W+1)'(w_acc) + RND_HALF;
        w_shr = w_rnd >>> SHIFT;
        // In range exactly when all bits from the output sign bit upward agree
        w_hi  = w_shr[ACC_W:BW_OUT-1];
        if ((&w_hi) || (~|w_hi)) begin
            w_sat = w_shr[BW_OUT-1:0];
        end else if (w_shr[ACC_W]) begin
            w_sat = OUT_MIN;
        end else begin
            w_sat = OUT_MAX;
        end
    end

    // -----------------------------------------------------------------------
    // Output stage. out_data is held while the result waits for out_ready;
    // a new sample can only arrive when the slot is free or being drained.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (load_start) begin
            r_out_valid <= 1'b0;
        end else if (w_smp_acc) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sat;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_param_fir.sv
module tb_param_fir;

    localparam int N   = 4;
    localparam int BWI = 6;
    localparam int BWC = 6;
    localparam int BWO = 8;
    localparam int SH  = 4;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   load_start = 1'b0;
    logic                   coef_valid = 1'b0;
    logic signed [BWC-1:0]  coef_data = '0;
    logic                   coef_ready;
    logic                   in_valid = 1'b0;
    logic signed [BWI-1:0]  in_data = '0;
    logic                   in_ready;
    logic                   out_valid;
    logic signed [BWO-1:0]  out_data;
    logic                   out_ready = 1'b0;
    logic                   running;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_h [N];
    int m_hist[$];     // past samples, most recent first
    int exp_q[$];      // results produced but not yet consumed
    int seen_q[$];     // results observed leaving the DUT
    bit m_running;
    int last_out;

    param_fir #(.N_TAPS(N), .BW_IN(BWI), .BW_COEF(BWC), .BW_OUT(BWO), .SHIFT(SH)) dut (
        .clk(clk), .reset_n(reset_n), .load_start(load_start),
        .coef_valid(coef_valid), .coef_data(coef_data), .coef_ready(coef_ready),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .running(running)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void model_clear_hist();
        m_hist.delete();
        for (int k = 0; k < N - 1; k++) m_hist.push_back(0);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < N; k++) m_h[k] = 0;
        model_clear_hist();
        exp_q.delete();
        m_running = 0;
    endfunction

    // y = sum h[k]*x[n-k]; round half up by adding 2^(SH-1) then floor-divide.
    function automatic int model_y(int x);
        longint acc;
        longint r;
        longint lim_hi;
        longint lim_lo;
        acc = longint'(m_h[0]) * x;
        for (int k = 1; k < N; k++) acc += longint'(m_h[k]) * m_hist[k-1];
        r = (acc + (longint'(1) <<< (SH - 1))) >>> SH;
        lim_hi = (longint'(1) <<< (BWO - 1)) - 1;
        lim_lo = -(longint'(1) <<< (BWO - 1));
        if (r > lim_hi) r = lim_hi;
        if (r < lim_lo) r = lim_lo;
        return int'(r);
    endfunction

    // One clock of streaming: check outputs, then drive the next inputs.
    task automatic drive_cycle(input bit v, input int x, input bit rdy);
        bit exp_rdy;
        @(negedge clk);
        n_checks++;
        if (out_valid !== (exp_q.size() > 0)) begin
            n_fail++;
            $display("FAIL out_valid: got %b want %0d", out_valid, exp_q.size() > 0);
        end
        if (out_valid === 1'b1 && exp_q.size() > 0) begin
            n_checks++;
            if (out_data !== exp_q[0]) begin
                n_fail++;
                $display("FAIL out_data: got %0d want %0d", out_data, exp_q[0]);
            end
            last_out = out_data;
        end
        n_checks++;
        if (running !== m_running) begin
            n_fail++;
            $display("FAIL running: got %b want %b", running, m_running);
        end
        out_ready = rdy;
        #1;
        exp_rdy = m_running && (exp_q.size() == 0 || rdy);
        n_checks++;
        if (in_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL in_ready: got %b want %b", in_ready, exp_rdy);
        end
        if (exp_q.size() > 0 && rdy) begin
            seen_q.push_back(int'(out_data));
            void'(exp_q.pop_front());
        end
        in_valid = v;
        in_data  = BWI'(x);
        if (v && exp_rdy) begin
            exp_q.push_back(model_y(x));
            m_hist.push_front(x);
            void'(m_hist.pop_back());
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) drive_cycle(0, 0, 1);
    endtask

    // c0 is loaded first and lands in h[N-1]; c3 is h[0].
    task automatic load_coefs(input int c0, input int c1, input int c2, input int c3);
        int c [N];
        int i;
        int guard;
        bit cv;
        c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
        i = 0;
        guard = 0;
        while (i < N && guard < 200) begin
            @(negedge clk);
            guard++;
            in_valid = 1'b0;
            n_checks++;
            if (coef_ready !== 1'b1 || in_ready !== 1'b0 || running !== 1'b0) begin
                n_fail++;
                $display("FAIL load_state: coef_ready=%b in_ready=%b running=%b want 1,0,0",
                         coef_ready, in_ready, running);
            end
            cv = ($urandom_range(0, 3) != 0);
            coef_valid = cv;
            coef_data  = cv ? BWC'(c[i]) : BWC'($urandom);
            if (cv) begin
                m_h[N-1-i] = c[i];
                i++;
            end
        end
        if (i < N) begin
            n_fail++;
            $display("FAIL load_timeout: loaded %0d want %0d", i, N);
        end
        @(negedge clk);
        coef_valid = 1'b0;
        n_checks++;
        if (running !== 1'b1 || coef_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_done: running=%b coef_ready=%b want 1,0", running, coef_ready);
        end
        m_running = 1;
    endtask

    task automatic do_load_start(input bit v, input int x);
        @(negedge clk);
        load_start = 1'b1;
        in_valid   = v;
        in_data    = BWI'(x);
        coef_valid = 1'b1;
        coef_data  = BWC'($urandom);
        out_ready  = 1'b0;
        @(negedge clk);
        load_start = 1'b0;
        in_valid   = 1'b0;
        coef_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || running !== 1'b0 || coef_ready !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_start: out_valid=%b running=%b coef_ready=%b in_ready=%b want 0,0,1,0",
                     out_valid, running, coef_ready, in_ready);
        end
        model_clear_hist();
        exp_q.delete();
        m_running = 0;
    endtask

    task automatic check_seen(input string name, input int e0, input int e1,
                              input int e2, input int e3, input int e4, input int cnt);
        int e [5];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
        n_checks++;
        if (seen_q.size() != cnt) begin
            n_fail++;
            $display("FAIL %s_count: got %0d want %0d", name, seen_q.size(), cnt);
        end else begin
            for (int i = 0; i < cnt; i++) begin
                n_checks++;
                if (seen_q[i] !== e[i]) begin
                    n_fail++;
                    $display("FAIL %s[%0d]: got %0d want %0d", name, i, seen_q[i], e[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        #12;
        n_checks++;
        if ({coef_ready, in_ready, out_valid, running, out_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got cr=%b ir=%b ov=%b run=%b od=%0d want all 0",
                     coef_ready, in_ready, out_valid, running, out_data);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (coef_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_early: coef_ready=%b want 0", coef_ready);
        end
        @(negedge clk);
        n_checks++;
        if (coef_ready !== 1'b1 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: coef_ready=%b running=%b want 1,0", coef_ready, running);
        end
    endtask

    task automatic test_reset_midload();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            coef_valid = 1'b1;
            coef_data  = BWC'(i + 5);
        end
        @(negedge clk);
        coef_valid = 1'b0;
        reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (coef_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midload_reset: coef_ready=%b want 0", coef_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_impulse();
        load_coefs(4, 3, 2, 1);
        seen_q.delete();
        drive_cycle(1, 16, 1);
        for (int i = 0; i < 4; i++) drive_cycle(1, 0, 1);
        drain();
        check_seen("impulse", 1, 2, 3, 4, 0, 5);
    endtask

    task automatic test_rounding();
        do_load_start(0, 0);
        load_coefs(0, 0, 0, 1);
        seen_q.delete();
        drive_cycle(1, 8, 1);
        drive_cycle(1, 7, 1);
        drive_cycle(1, -8, 1);
        drive_cycle(1, -9, 1);
        drain();
        check_seen("rounding", 1, 0, 0, -1, 0, 4);
    endtask

    task automatic test_saturation();
        do_load_start(0, 0);
        load_coefs(31, 31, 31, 31);
        for (int i = 0; i < 6; i++) drive_cycle(1, 31, 1);
        drain();
        n_checks++;
        if (last_out !== 127) begin
            n_fail++;
            $display("FAIL sat_pos: got %0d want 127", last_out);
        end
        for (int i = 0; i < 6; i++) drive_cycle(1, -32, 1);
        drain();
        n_checks++;
        if (last_out !== -128) begin
            n_fail++;
            $display("FAIL sat_neg: got %0d want -128", last_out);
        end
    endtask

    task automatic test_backpressure();
        do_load_start(0, 0);
        load_coefs(4, 3, 2, 1);
        seen_q.delete();
        drive_cycle(1, 20, 1);
        for (int i = 0; i < 5; i++) drive_cycle(1, int'($urandom_range(0, 63)) - 32, 0);
        for (int i = 0; i < 6; i++) drive_cycle(1, i * 3 - 7, 1);
        drain();
        n_checks++;
        if (seen_q.size() != 7) begin
            n_fail++;
            $display("FAIL backpressure_count: got %0d want 7", seen_q.size());
        end
    endtask

    task automatic test_load_start_midstream();
        drive_cycle(1, 10, 1);
        drive_cycle(1, 11, 1);
        do_load_start(1, 12);
        load_coefs(0, 0, 0, 1);
        seen_q.delete();
        drive_cycle(1, 16, 1);
        drain();
        check_seen("reload_h0", 1, 0, 0, 0, 0, 1);
        // Non-zero taps on old history: stale samples would change the result.
        drive_cycle(1, 31, 1);
        drive_cycle(1, 30, 1);
        drive_cycle(1, -29, 1);
        do_load_start(1, 25);
        load_coefs(1, 2, 3, 4);
        seen_q.delete();
        drive_cycle(1, 16, 1);
        drive_cycle(1, 0, 1);
        drain();
        check_seen("reload_full", 4, 3, 0, 0, 0, 2);
    endtask

    task automatic test_random();
        do_load_start(0, 0);
        load_coefs(int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 63)) - 32,
                   int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 63)) - 32);
        for (int i = 0; i < 200; i++) begin
            drive_cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 63)) - 32,
                        $urandom_range(0, 9) < 7);
        end
        drain();
    endtask

    task automatic test_reset_mid_run();
        drive_cycle(1, 10, 0);
        @(posedge clk);
        #2;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_valid: got %b want 1", out_valid);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({coef_ready, in_ready, out_valid, running, out_data} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: cr=%b ir=%b ov=%b run=%b od=%0d want all 0",
                     coef_ready, in_ready, out_valid, running, out_data);
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        load_coefs(4, 3, 2, 1);
        seen_q.delete();
        drive_cycle(1, 16, 1);
        drain();
        check_seen("after_reset", 1, 0, 0, 0, 0, 1);
    endtask

    initial begin
        test_reset();
        test_reset_midload();
        test_impulse();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_load_start_midstream();
        test_random();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
